dma_burst_ctrl: RTL

DMA_BURST_CTRL -- requirements
Module: dma_burst_ctrl

---
 rtl/dma_burst_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/dma_burst_ctrl.sv
// dma_burst_ctrl: single-port RAM burst engine for reads into a stream sink and writes from a handshaked source
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   start, rw, base_addr, length      burst request (rw=1 read, rw=0 write), sampled only in IDLE
//   busy, done, error                 status; error pulses one cycle on an illegal length
//   mem_en, mem_rw, mem_addr,
//   mem_wdata, mem_rdata              RAM port, read data returns one cycle after the address
//   wr_data, wr_valid, wr_ready       write source handshake
//   rd_data, rd_valid, rd_index       read sink stream, no backpressure
module dma_burst_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [4:0]            length,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  mem_en,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [4:0]            rd_index
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [4:0]            r_len;
    logic                  r_rw;
    logic [4:0]            r_i;
    logic                  r_rd_valid;
    logic [4:0]            r_rd_index;
    logic                  r_error;
    logic                  w_en;
    logic                  w_last;
    logic                  w_len_ok;
    // Write strobes follow wr_valid in the same cycle, so the RAM port is decoded from state rather than registered.
    assign w_en     = (r_state == S_READ) || (r_state == S_WRITE && wr_valid);
    assign w_last   = r_i == r_len - 5'd1;
    assign w_len_ok = length != 5'd0 && length <= 5'(MAX_BURST);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_rw       <= 1'b0;
            r_i        <= '0;
            r_rd_valid <= 1'b0;
            r_rd_index <= '0;
            r_error    <= 1'b0;
        end else begin
            r_error    <= 1'b0;
            // Each read issue yields a stream beat one cycle later, when the RAM returns its data.
            r_rd_valid <= r_state == S_READ;
            r_rd_index <= r_i;
            case (r_state)
                S_IDLE: begin
                    if (start && w_len_ok) begin
                        r_base  <= base_addr;
                        r_len   <= length;
                        r_rw    <= rw;
                        r_i     <= '0;
                        r_state <= rw ? S_READ : S_WRITE;
                    end else if (start) begin
                        r_error <= 1'b1;
                    end
                end
                S_READ: begin
                    r_i     <= r_i + 5'd1;
                    r_state <= w_last ? S_DRAIN : S_READ;
                end
                S_DRAIN: r_state <= S_DONE;
                S_WRITE: begin
                    if (wr_valid) begin
                        r_i     <= r_i + 5'd1;
                        r_state <= w_last ? S_DONE : S_WRITE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign busy      = r_state != S_IDLE;
    assign done      = r_state == S_DONE;
    assign error     = r_error;
    assign mem_en    = w_en;
    assign mem_rw    = w_en & r_rw;
    assign mem_addr  = w_en ? r_base + ADDR_WIDTH'(r_i) : '0;
    assign mem_wdata = (w_en && !r_rw) ? wr_data : '0;
    assign wr_ready  = r_state == S_WRITE;
    assign rd_valid  = r_rd_valid;
    assign rd_index  = r_rd_valid ? r_rd_index : '0;
    assign rd_data   = r_rd_valid ? mem_rdata : '0;
endmodule
